// File: rtl/sat_pkg.sv
// Shared sizing for the SAT clause hardware: default clause width,
// default variable count and the index-width helper.
package sat_pkg;

   localparam int DEFAULT_VAR_PER_CLAUSE = 5;
   localparam int DEFAULT_NUM_VARIABLE   = 128;

   // Never returns 0, so a one-entry table still gets a usable 1-bit index.
   function automatic int varWidth(input int count);
      return (count <= 1) ? 1 : $clog2(count);
   endfunction

endpackage

// File: rtl/sub_clause_literal_select.sv
// Counts the active unassigned slots and selects the variable index and polarity
// of the selected slot. The selection is meaningful only when exactly one slot is set.
module sub_clause_literal_select
   import sat_pkg::*;
#(
   parameter int VAR_PER_CLAUSE = DEFAULT_VAR_PER_CLAUSE,
   parameter int NUM_VARIABLE   = DEFAULT_NUM_VARIABLE,
   localparam int VW = varWidth(NUM_VARIABLE),
   localparam int SW = varWidth(VAR_PER_CLAUSE)
) (
   input  logic [VAR_PER_CLAUSE-1:0]         activeUnassigned_i,
   input  logic [VAR_PER_CLAUSE-1:0][VW-1:0] variable_i,
   input  logic [VAR_PER_CLAUSE-1:0]         pole_i,
   output logic                              countIsOne_o,
   output logic [SW-1:0]                     slot_o,
   output logic [VW-1:0]                     selVariable_o,
   output logic                              selPole_o
);

   localparam int CW = $clog2(VAR_PER_CLAUSE + 1);

   logic [CW-1:0] unassignedCount;

   // A plain population count; the last set slot wins the mux, which is
   // unambiguous whenever the count is one.
   always_comb begin
      unassignedCount = '0;
      slot_o          = '0;
      selVariable_o   = '0;
      selPole_o       = 1'b0;
      for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
         unassignedCount = unassignedCount + CW'(activeUnassigned_i[i]);
         if (activeUnassigned_i[i]) begin
            slot_o        = SW'(i);
            selVariable_o = variable_i[i];
            selPole_o     = pole_i[i];
         end
      end
   end

   assign countIsOne_o = (unassignedCount == CW'(1));

endmodule

// File: rtl/sub_clause_evaluator.sv
// Evaluates one sub-clause under the current partial assignment and registers
// whether it is unit (with the implied literal) or in conflict.
module sub_clause_evaluator
   import sat_pkg::*;
#(
   parameter int VAR_PER_CLAUSE = DEFAULT_VAR_PER_CLAUSE,
   parameter int NUM_VARIABLE   = DEFAULT_NUM_VARIABLE,
   localparam int VW = varWidth(NUM_VARIABLE),
   localparam int SW = varWidth(VAR_PER_CLAUSE)
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [VAR_PER_CLAUSE-1:0]         unassign,
   input  logic [VAR_PER_CLAUSE-1:0]         clause_mask,
   input  logic [VAR_PER_CLAUSE-1:0]         clause_pole,
   input  logic [VAR_PER_CLAUSE-1:0]         val,
   input  logic [VAR_PER_CLAUSE-1:0][VW-1:0] variable,
   output logic                              new_val,
   output logic [VW-1:0]                     implied_variable,
   output logic                              unit_clause,
   output logic                              conflict
);

   logic [VAR_PER_CLAUSE-1:0] activeUnassigned;
   logic [VAR_PER_CLAUSE-1:0] activeTrue;
   logic                      anyActive;
   logic                      anyTrue;
   logic                      countIsOne;
   logic [SW-1:0]             selSlot;
   logic [VW-1:0]             selVariable;
   logic                      selPole;

   logic                      unit_d,     unit_q;
   logic                      conflict_d, conflict_q;
   logic                      newVal_d,   newVal_q;
   logic [VW-1:0]             implied_d,  implied_q;

   // An assigned literal is true when its value differs from its negation flag.
   assign activeUnassigned = clause_mask & unassign;
   assign activeTrue       = clause_mask & ~unassign & (val ^ clause_pole);
   assign anyActive        = |clause_mask;
   assign anyTrue          = |activeTrue;

   sub_clause_literal_select #(
      .VAR_PER_CLAUSE(VAR_PER_CLAUSE),
      .NUM_VARIABLE  (NUM_VARIABLE)
   ) u_select (
      .activeUnassigned_i(activeUnassigned),
      .variable_i        (variable),
      .pole_i            (clause_pole),
      .countIsOne_o      (countIsOne),
      .slot_o            (selSlot),
      .selVariable_o     (selVariable),
      .selPole_o         (selPole)
   );

   // Unit needs a lone unassigned literal and no satisfied one; the slot
   // lookup confirms the mux really landed on that live literal.
   always_comb begin
      unit_d     = countIsOne && !anyTrue && activeUnassigned[selSlot];
      conflict_d = anyActive && (activeUnassigned == '0) && !anyTrue;
      newVal_d   = 1'b0;
      implied_d  = '0;
      if (unit_d) begin
         newVal_d  = ~selPole;
         implied_d = selVariable;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         unit_q     <= 1'b0;
         conflict_q <= 1'b0;
         newVal_q   <= 1'b0;
         implied_q  <= '0;
      end else begin
         unit_q     <= unit_d;
         conflict_q <= conflict_d;
         newVal_q   <= newVal_d;
         implied_q  <= implied_d;
      end
   end

   assign unit_clause      = unit_q;
   assign conflict         = conflict_q;
   assign new_val          = newVal_q;
   assign implied_variable = implied_q;

endmodule

// File: tb/tb_sub_clause_evaluator.sv
// Directed and random checks of sub_clause_evaluator against a slot-counting
// reference model of the clause rules.
module tb_sub_clause_evaluator;

   localparam int N  = 5;
   localparam int VW = 7;

   logic                 clock;
   logic                 reset;
   logic [N-1:0]         unassign;
   logic [N-1:0]         clause_mask;
   logic [N-1:0]         clause_pole;
   logic [N-1:0]         val;
   logic [N-1:0][VW-1:0] variable;
   logic                 new_val;
   logic [VW-1:0]        implied_variable;
   logic                 unit_clause;
   logic                 conflict;

   int testCount = 0;
   int failCount = 0;

   logic          expUnit;
   logic          expConflict;
   logic          expNewVal;
   logic [VW-1:0] expImplied;

   sub_clause_evaluator dut (
      .clock           (clock),
      .reset           (reset),
      .unassign        (unassign),
      .clause_mask     (clause_mask),
      .clause_pole     (clause_pole),
      .val             (val),
      .variable        (variable),
      .new_val         (new_val),
      .implied_variable(implied_variable),
      .unit_clause     (unit_clause),
      .conflict        (conflict)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference: count unassigned and satisfied literals among the active slots.
   task automatic computeExpected();
      int nActive = 0;
      int nUnassigned = 0;
      int nTrue = 0;
      int lastFree = -1;
      for (int i = 0; i < N; i++) begin
         if (clause_mask[i]) begin
            nActive++;
            if (unassign[i]) begin
               nUnassigned++;
               lastFree = i;
            end else if (val[i] != clause_pole[i]) begin
               nTrue++;
            end
         end
      end
      expUnit     = (nUnassigned == 1) && (nTrue == 0);
      expConflict = (nActive > 0) && (nUnassigned == 0) && (nTrue == 0);
      expNewVal   = expUnit ? !clause_pole[lastFree] : 1'b0;
      expImplied  = expUnit ? variable[lastFree] : '0;
   endtask

   task automatic expectZero();
      expUnit     = 1'b0;
      expConflict = 1'b0;
      expNewVal   = 1'b0;
      expImplied  = '0;
   endtask

   task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkOne({tag, ".unit"},     32'(unit_clause),      32'(expUnit));
      checkOne({tag, ".conflict"}, 32'(conflict),         32'(expConflict));
      checkOne({tag, ".newVal"},   32'(new_val),          32'(expNewVal));
      checkOne({tag, ".implied"},  32'(implied_variable), 32'(expImplied));
      checkOne({tag, ".exclusive"}, 32'(unit_clause & conflict), 32'(0));
   endtask

   task automatic randomVariables();
      for (int i = 0; i < N; i++) variable[i] = VW'($urandom);
   endtask

   // Drive on the falling edge, let one rising edge register, check just after it.
   task automatic applyStimulus(input logic [N-1:0] u, input logic [N-1:0] m,
                                input logic [N-1:0] p, input logic [N-1:0] v,
                                input string tag);
      @(negedge clock);
      unassign    = u;
      clause_mask = m;
      clause_pole = p;
      val         = v;
      @(posedge clock);
      #1;
      computeExpected();
      checkOutput(tag);
   endtask

   initial begin
      reset = 1'b1;
      unassign    = N'($urandom);
      clause_mask = N'($urandom);
      clause_pole = N'($urandom);
      val         = N'($urandom);
      randomVariables();

      #1;
      expectZero();
      checkOutput("resetHeld");
      repeat (2) @(posedge clock);
      #1;
      checkOutput("resetAcrossEdges");

      @(negedge clock);
      unassign    = 5'b11111;
      clause_mask = 5'b00000;
      reset       = 1'b0;
      @(posedge clock);
      #1;
      computeExpected();
      checkOutput("allMasked");

      applyStimulus(5'b10000, 5'b11111, 5'b00000, 5'b00000, "unitSlot4Pos");
      applyStimulus(5'b10000, 5'b11111, 5'b10000, 5'b00000, "unitSlot4Neg");
      applyStimulus(5'b00100, 5'b11110, 5'b00000, 5'b00000, "unitSlot2Masked0");
      applyStimulus(5'b00001, 5'b11111, 5'b00000, 5'b11110, "satisfiedA");
      applyStimulus(5'b00001, 5'b11111, 5'b00000, 5'b00010, "satisfiedB");
      applyStimulus(5'b11111, 5'b11111, 5'b00000, 5'b00000, "allUnassigned");
      applyStimulus(5'b00000, 5'b11111, 5'b00000, 5'b00000, "conflictAll");

      // Mid-cycle reset must clear the registered conflict before any edge.
      #2;
      reset = 1'b1;
      #1;
      expectZero();
      checkOutput("midCycleReset");
      @(negedge clock);
      reset = 1'b0;
      #1;
      checkOutput("afterReleaseBeforeEdge");
      @(posedge clock);
      #1;
      computeExpected();
      checkOutput("firstEdgeAfterRelease");

      for (int n = 0; n < 300; n++) begin
         randomVariables();
         applyStimulus(N'($urandom & $urandom), N'($urandom | $urandom),
                       N'($urandom), N'($urandom), "random");
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/sub_clause_evaluator.md
SUB_CLAUSE_EVALUATOR -- requirements
Module: sub_clause_evaluator

Interface
REQ-001 The block SHALL have parameter VAR_PER_CLAUSE, default 5: literal slots per sub-clause.
REQ-002 The block SHALL have parameter NUM_VARIABLE, default 128: variable count; variable index width VW = $clog2(NUM_VARIABLE), which is 7 by default.
REQ-003 The block SHALL have port clock, input, 1 bit: single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port unassign, input, VAR_PER_CLAUSE bits: bit i=1 means variable in slot i is unassigned.
REQ-006 The block SHALL have port clause_mask, input, VAR_PER_CLAUSE bits: bit i=1 means slot i holds a valid literal.
REQ-007 The block SHALL have port clause_pole, input, VAR_PER_CLAUSE bits: bit i=1 means slot i is a negated literal.
REQ-008 The block SHALL have port val, input, VAR_PER_CLAUSE bits: current assigned value of the slot-i variable, meaningful only when assigned.
REQ-009 The block SHALL have port variable, input, packed [VAR_PER_CLAUSE][VW]: variable index per slot.
REQ-010 The block SHALL have port new_val, output, 1 bit: value to assign to the implied variable.
REQ-011 The block SHALL have port implied_variable, output, VW bits: index of the implied variable.
REQ-012 The block SHALL have port unit_clause, output, 1 bit: the sub-clause is unit.
REQ-013 The block SHALL have port conflict, output, 1 bit: all valid literals are assigned and false.

Function
REQ-014 Slot i SHALL be active iff clause_mask[i]=1; inactive slots SHALL be ignored regardless of unassign, val, pole or variable.
REQ-015 An active assigned slot (unassign[i]=0) SHALL be true iff val[i] != clause_pole[i], and false iff val[i] == clause_pole[i].
REQ-016 unit_clause SHALL be 1 iff exactly one active slot is unassigned and every other active slot is assigned-false.
REQ-017 When unit_clause=1 with unassigned slot k, new_val SHALL be ~clause_pole[k] and implied_variable SHALL be variable[k].
REQ-018 When unit_clause=0, new_val and implied_variable SHALL be 0.
REQ-019 Any active assigned-true slot SHALL force unit_clause=0 and conflict=0.
REQ-020 Zero, or two or more, active unassigned slots SHALL give unit_clause=0.
REQ-021 conflict SHALL be 1 iff at least one slot is active, no active slot is unassigned, and all active slots are false; all-masked SHALL give conflict=0 and unit_clause=0.
REQ-022 Evaluation SHALL be combinational from the inputs; all outputs SHALL be registered on the rising clock edge, giving exactly 1-cycle latency with no handshake.
REQ-023 Inputs SHALL be resampled every cycle, with no state other than the output registers.
REQ-024 unit_clause and conflict SHALL never both be 1.

Reset
REQ-025 While reset=1, asynchronously, new_val, implied_variable, unit_clause and conflict SHALL all be 0.
REQ-026 The first rising clock edge after reset deasserts SHALL register the evaluation of the current inputs.
REQ-027 Reset asserted mid-operation SHALL clear all outputs immediately, regardless of the clock.

Structure
REQ-028 VAR_PER_CLAUSE and NUM_VARIABLE defaults and the VW width function SHALL live in a shared package, sat_pkg.
REQ-029 Unassigned-slot one-hot detection and index mux SHALL be one sub-module, sub_clause_literal_select, with inputs the active-unassigned vector and the variable array, and outputs count-is-one, slot k, variable[k] and pole[k].
REQ-030 The top level SHALL hold literal truth logic, unit/conflict decode and output registers.

Verification
REQ-031 reset=1 with any inputs -> all outputs 0; after release with unassign=11111, mask=00000 -> unit_clause=0, conflict=0.
REQ-032 unassign=10000, mask=11111, pole=00000, val=00000 -> next edge: unit_clause=1, new_val=1, implied_variable=variable[4].
REQ-033 Same as REQ-032 but pole=10000 -> unit_clause=1, new_val=0, implied_variable=variable[4].
REQ-034 unassign=00100, mask=11110, pole=00000, val=00000 -> unit_clause=1, new_val=1, implied_variable=variable[2]; a masked slot 0 is ignored.
REQ-035 unassign=00001, mask=11111, pole=00000 with val=11110 or val=00010 -> unit_clause=0, conflict=0 (satisfied); unassign=11111 -> unit_clause=0.
REQ-036 unassign=00000, mask=11111, pole=00000, val=00000 -> conflict=1, unit_clause=0; asserting reset mid-cycle -> outputs 0 before the next edge.
